// File: rtl/negate_arbiter.sv
// rtl/negate_arbiter.sv - round-robin arbiter sharing one two's-complement negation datapath
module negate_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 4,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [IDW-1:0]        out_id,
  output logic                  out_ovf
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state;
  logic [IDW-1:0]   rr_ptr;

  logic [WIDTH-1:0] ops [NREQ];
  logic [IDW:0]     scan_sum;
  logic [IDW-1:0]   scan_idx;
  logic             found;
  logic [IDW-1:0]   win_id;
  logic [WIDTH-1:0] win_data;
  logic [IDW-1:0]   next_ptr;

  // Unflatten the operand bus so each requester's operand is addressable by ID.
  for (genvar i = 0; i < NREQ; i++) begin : g_ops
    assign ops[i] = req_data[i*WIDTH +: WIDTH];
  end

  // Round-robin scan starting at rr_ptr; the first active request wins.
  always_comb begin
    found    = 1'b0;
    win_id   = '0;
    win_data = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (scan_sum >= (IDW+1)'(NREQ)) begin
        scan_sum = scan_sum - (IDW+1)'(NREQ);
      end
      scan_idx = scan_sum[IDW-1:0];
      if (!found && req[scan_idx]) begin
        found    = 1'b1;
        win_id   = scan_idx;
        win_data = ops[scan_idx];
      end
    end
  end

  // Pointer moves just past the winner so it becomes lowest priority next time.
  always_comb begin
    next_ptr = '0;
    if (win_id != IDW'(NREQ-1)) begin
      next_ptr = win_id + IDW'(1);
    end
  end

  // Two-state controller: capture and negate in IDLE, hold the result until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          gnt <= '0;
          if (found) begin
            gnt       <= NREQ'(1) << win_id;
            out_data  <= ~win_data + WIDTH'(1);
            out_ovf   <= (win_data == MOST_NEG);
            out_id    <= win_id;
            out_valid <= 1'b1;
            rr_ptr    <= next_ptr;
            state     <= HOLD;
          end
        end
        HOLD: begin
          // Grant is a single-cycle pulse; requests are ignored until the result drains.
          gnt <= '0;
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          gnt       <= '0;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_negate_arbiter.sv
// tb/tb_negate_arbiter.sv - directed self-checking bench for negate_arbiter
module tb_negate_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] req_data;
  logic [3:0]  gnt;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;
  logic [1:0]  out_id;
  logic        out_ovf;

  int passed;
  int total;

  negate_arbiter #(.NREQ(4), .WIDTH(4), .IDW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; req_data = '0; out_ready = 1'b0;
    tick(); tick();
    total++; if (gnt !== 4'b0000) $display("FAIL reset_gnt got %b want 0000", gnt); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else passed++;
    total++; if (out_data !== 4'b0000) $display("FAIL reset_data got %b want 0000", out_data); else passed++;
    total++; if (out_id !== 2'd0) $display("FAIL reset_id got %0d want 0", out_id); else passed++;
    total++; if (out_ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", out_ovf); else passed++;
    rst_n = 1'b1;
    tick();
    total++; if (gnt !== 4'b0000 || out_valid !== 1'b0) $display("FAIL idle_noreq got gnt=%b valid=%b want 0000/0", gnt, out_valid); else passed++;
  endtask

  task automatic test_single();
    req = 4'b0001; req_data[3:0] = 4'b0011; out_ready = 1'b1;
    tick();
    total++; if (gnt !== 4'b0001) $display("FAIL single_gnt got %b want 0001", gnt); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL single_valid got %b want 1", out_valid); else passed++;
    total++; if (out_data !== 4'b1101) $display("FAIL single_data got %b want 1101", out_data); else passed++;
    total++; if (out_id !== 2'd0) $display("FAIL single_id got %0d want 0", out_id); else passed++;
    total++; if (out_ovf !== 1'b0) $display("FAIL single_ovf got %b want 0", out_ovf); else passed++;
    req = 4'b0000;
    tick();
    total++; if (gnt !== 4'b0000) $display("FAIL single_gnt_pulse got %b want 0000", gnt); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL single_drain got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_round_robin();
    logic [3:0] rr_in  [4];
    logic [3:0] rr_out [4];
    logic [3:0] rr_gnt [4];
    int id;
    rr_in  = '{4'b0001, 4'b0010, 4'b0110, 4'b0111};
    rr_out = '{4'b1111, 4'b1110, 4'b1010, 4'b1001};
    rr_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    rst_n = 1'b0; #1; rst_n = 1'b1;
    for (int i = 0; i < 4; i++) req_data[i*4 +: 4] = rr_in[i];
    req = 4'b1111; out_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      id = g % 4;
      tick();
      total++; if (gnt !== rr_gnt[id]) $display("FAIL rr_gnt[%0d] got %b want %b", g, gnt, rr_gnt[id]); else passed++;
      total++; if (out_id !== 2'(id)) $display("FAIL rr_id[%0d] got %0d want %0d", g, out_id, id); else passed++;
      total++; if (out_data !== rr_out[id]) $display("FAIL rr_data[%0d] got %b want %b", g, out_data, rr_out[id]); else passed++;
      req[id] = 1'b0;
      tick();
      total++; if (gnt !== 4'b0000 || out_valid !== 1'b0) $display("FAIL rr_gap[%0d] got gnt=%b valid=%b want 0000/0", g, gnt, out_valid); else passed++;
      req[id] = 1'b1;
    end
    req = 4'b0000;
  endtask

  task automatic test_backpressure();
    req = 4'b0100; req_data[11:8] = 4'b0101; out_ready = 1'b0;
    tick();
    total++; if (gnt !== 4'b0100) $display("FAIL bp_gnt got %b want 0100", gnt); else passed++;
    req = 4'b0010; req_data[7:4] = 4'b0011;
    for (int c = 0; c < 5; c++) begin
      tick();
      total++; if (gnt !== 4'b0000) $display("FAIL bp_nognt[%0d] got %b want 0000", c, gnt); else passed++;
      total++; if (out_valid !== 1'b1 || out_data !== 4'b1011 || out_id !== 2'd2)
        $display("FAIL bp_hold[%0d] got valid=%b data=%b id=%0d want 1/1011/2", c, out_valid, out_data, out_id); else passed++;
    end
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0 || gnt !== 4'b0000) $display("FAIL bp_release got valid=%b gnt=%b want 0/0000", out_valid, gnt); else passed++;
    tick();
    total++; if (gnt !== 4'b0010 || out_data !== 4'b1101 || out_id !== 2'd1)
      $display("FAIL bp_next got gnt=%b data=%b id=%0d want 0010/1101/1", gnt, out_data, out_id); else passed++;
    req = 4'b0000;
    tick();
  endtask

  task automatic test_boundary();
    logic [3:0] b_in  [4];
    logic [3:0] b_out [4];
    logic       b_ovf [4];
    b_in  = '{4'b1000, 4'b0000, 4'b1111, 4'b0111};
    b_out = '{4'b1000, 4'b0000, 4'b0001, 4'b1001};
    b_ovf = '{1'b1, 1'b0, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      req = 4'b0001; req_data[3:0] = b_in[v];
      tick();
      total++; if (out_data !== b_out[v] || out_ovf !== b_ovf[v] || out_valid !== 1'b1)
        $display("FAIL bound[%b] got data=%b ovf=%b valid=%b want %b/%b/1", b_in[v], out_data, out_ovf, out_valid, b_out[v], b_ovf[v]); else passed++;
      req = 4'b0000;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    req = 4'b1000; req_data[15:12] = 4'b0010; out_ready = 1'b0;
    tick();
    total++; if (gnt !== 4'b1000 || out_id !== 2'd3 || out_data !== 4'b1110)
      $display("FAIL rm_pre got gnt=%b id=%0d data=%b want 1000/3/1110", gnt, out_id, out_data); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || gnt !== 4'b0000 || out_id !== 2'd0 || out_data !== 4'b0000)
      $display("FAIL rm_async got valid=%b gnt=%b id=%0d data=%b want 0/0000/0/0000", out_valid, gnt, out_id, out_data); else passed++;
    req = 4'b0000;
    tick();
    rst_n = 1'b1;
    tick();
    total++; if (gnt !== 4'b0000 || out_valid !== 1'b0) $display("FAIL rm_discard got gnt=%b valid=%b want 0000/0", gnt, out_valid); else passed++;
    req = 4'b0101; req_data[3:0] = 4'b0100; req_data[11:8] = 4'b0001;
    tick();
    total++; if (gnt !== 4'b0001 || out_id !== 2'd0 || out_data !== 4'b1100)
      $display("FAIL rm_first got gnt=%b id=%0d data=%b want 0001/0/1100", gnt, out_id, out_data); else passed++;
    req = 4'b0000; out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL rm_drain got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    req = 4'b0100; req_data[11:8] = 4'b0001;
    tick();
    total++; if (gnt !== 4'b0100) $display("FAIL wrap_g2 got %b want 0100", gnt); else passed++;
    req = 4'b0000;
    tick();
    req = 4'b1001; req_data[15:12] = 4'b0011; req_data[3:0] = 4'b0101;
    tick();
    total++; if (gnt !== 4'b1000 || out_id !== 2'd3 || out_data !== 4'b1101)
      $display("FAIL wrap_g3 got gnt=%b id=%0d data=%b want 1000/3/1101", gnt, out_id, out_data); else passed++;
    req = 4'b0001;
    tick();
    total++; if (gnt !== 4'b0000 || out_valid !== 1'b0) $display("FAIL wrap_gap got gnt=%b valid=%b want 0000/0", gnt, out_valid); else passed++;
    tick();
    total++; if (gnt !== 4'b0001 || out_id !== 2'd0 || out_data !== 4'b1011)
      $display("FAIL wrap_g0 got gnt=%b id=%0d data=%b want 0001/0/1011", gnt, out_id, out_data); else passed++;
    req = 4'b0000;
    tick();
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_boundary();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
